// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent integer clock dividers; divisor changes take effect only at a period wrap.
// Defining CLOCK_DIVIDER_BANK_SYNC_EN adds a SYNC input that realigns all running channels to phase 0.
module clock_divider_bank #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [NUM_CH-1:0]           ENABLE,
    input  logic [NUM_CH-1:0]           LOAD,
    input  logic [NUM_CH*DIV_WIDTH-1:0] DIV,
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
    input  logic                        SYNC,
`endif
    output logic [NUM_CH-1:0]           CLK_OUT,
    output logic [NUM_CH-1:0]           TICK,
    output logic [NUM_CH-1:0]           ACTIVE
);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH:0]   ONE_WIDE = (DIV_WIDTH+1)'(1);

    logic sync_req;
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
    assign sync_req = SYNC;
`else
    assign sync_req = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_WIDTH-1:0] na, np, cnt;
        logic                 pend, run, clk_q, tick_q;
        logic [DIV_WIDTH-1:0] na_n, np_n, cnt_n, div_in, div_raw;
        logic                 pend_n, run_n, wrap;
        logic [DIV_WIDTH:0]   half_n;

        assign div_raw = DIV[k*DIV_WIDTH +: DIV_WIDTH];
        assign div_in  = (div_raw < MIN_DIV) ? MIN_DIV : div_raw;
        assign wrap    = (cnt == na - ONE);

        always_comb begin
            na_n   = na;
            np_n   = np;
            cnt_n  = cnt;
            pend_n = pend;
            run_n  = run;
            if (!ENABLE[k]) begin
                // Stopping: any pending divisor becomes active right away.
                run_n  = 1'b0;
                cnt_n  = '0;
                pend_n = 1'b0;
                if (LOAD[k])
                    na_n = div_in;
                else if (pend)
                    na_n = np;
            end else if (!run) begin
                run_n = 1'b1;
                cnt_n = '0;
                if (LOAD[k])
                    na_n = div_in;
            end else if (wrap || sync_req) begin
                cnt_n  = '0;
                pend_n = 1'b0;
                if (LOAD[k])
                    na_n = div_in;
                else if (pend)
                    na_n = np;
            end else begin
                cnt_n = cnt + ONE;
                if (LOAD[k]) begin
                    np_n   = div_in;
                    pend_n = 1'b1;
                end
            end
            half_n = ({1'b0, na_n} + ONE_WIDE) >> 1;
        end

        // Outputs are decoded from next state so they leave the flops aligned with the phase.
        always_ff @(posedge CLK) begin
            if (!RESET_N) begin
                na     <= MIN_DIV;
                np     <= MIN_DIV;
                cnt    <= '0;
                pend   <= 1'b0;
                run    <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                na     <= na_n;
                np     <= np_n;
                cnt    <= cnt_n;
                pend   <= pend_n;
                run    <= run_n;
                clk_q  <= run_n && ({1'b0, cnt_n} < half_n);
                tick_q <= run_n && (cnt_n == na_n - ONE);
            end
        end

        assign CLK_OUT[k] = clk_q;
        assign TICK[k]    = tick_q;
        assign ACTIVE[k]  = run;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: hand-computed output patterns per scenario.
module tb_clock_divider_bank;
    localparam int NUM_CH    = 4;
    localparam int DIV_WIDTH = 8;

    logic                        CLK;
    logic                        RESET_N;
    logic [NUM_CH-1:0]           ENABLE, LOAD, CLK_OUT, TICK, ACTIVE;
    logic [NUM_CH*DIV_WIDTH-1:0] DIV;
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
    logic                        SYNC;
`endif

    int n_cmp = 0;
    int n_err = 0;

    clock_divider_bank #(.NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .ENABLE  (ENABLE),
        .LOAD    (LOAD),
        .DIV     (DIV),
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
        .SYNC    (SYNC),
`endif
        .CLK_OUT (CLK_OUT),
        .TICK    (TICK),
        .ACTIVE  (ACTIVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stop channel ch while loading d, then enable it; returns at the c=0 view.
    task automatic start(input int ch, input logic [DIV_WIDTH-1:0] d);
        ENABLE[ch] = 1'b0;
        LOAD[ch]   = 1'b1;
        DIV[ch*DIV_WIDTH +: DIV_WIDTH] = d;
        step();
        LOAD[ch]   = 1'b0;
        ENABLE[ch] = 1'b1;
        step();
    endtask

    // Patterns are MSB-first: bit n-1 is the current cycle.
    task automatic run_pattern(input string tag, input int ch, input int n,
                               input logic [31:0] cp, input logic [31:0] tp);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_clk"}, 32'(CLK_OUT[ch]), 32'(cp[n-1-i]));
            chk({tag, "_tick"}, 32'(TICK[ch]), 32'(tp[n-1-i]));
            chk({tag, "_act"}, 32'(ACTIVE[ch]), 32'd1);
            step();
        end
    endtask

    initial begin
        logic [11:0] pc [4];
        logic [11:0] pt [4];
        logic [3:0]  ec, et;

        RESET_N = 1'b0;
        ENABLE  = '0;
        LOAD    = '0;
        DIV     = '0;
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
        SYNC    = 1'b0;
`endif
        step();
        step();
        chk("rst_clk", 32'(CLK_OUT), 32'd0);
        chk("rst_tick", 32'(TICK), 32'd0);
        chk("rst_act", 32'(ACTIVE), 32'd0);
        RESET_N = 1'b1;

        start(0, 8'd4);
        run_pattern("div4", 0, 8, 32'b11001100, 32'b00010001);

        start(0, 8'd5);
        run_pattern("div5", 0, 10, 32'b1110011100, 32'b0000100001);

        start(0, 8'd0);
        run_pattern("div0", 0, 4, 32'b1010, 32'b0101);
        start(0, 8'd1);
        run_pattern("div1", 0, 4, 32'b1010, 32'b0101);

        // Reload during a period: current 6-cycle period must complete first.
        start(0, 8'd6);
        run_pattern("r6a", 0, 2, 32'b11, 32'b00);
        chk("r6_c2_clk", 32'(CLK_OUT[0]), 32'd1);
        LOAD[0] = 1'b1;
        DIV[7:0] = 8'd3;
        step();
        LOAD[0] = 1'b0;
        run_pattern("r6b", 0, 9, 32'b000110110, 32'b001001001);

        // Two loads before the wrap: only the second (7) applies.
        chk("dbl_c0_clk", 32'(CLK_OUT[0]), 32'd1);
        LOAD[0] = 1'b1;
        DIV[7:0] = 8'd5;
        step();
        chk("dbl_c1_clk", 32'(CLK_OUT[0]), 32'd1);
        DIV[7:0] = 8'd7;
        step();
        LOAD[0] = 1'b0;
        chk("dbl_c2_tick", 32'(TICK[0]), 32'd1);
        step();
        run_pattern("dbl7", 0, 6, 32'b111100, 32'b000000);

        // Load coinciding with the wrap governs the very next period.
        chk("wrap_tick", 32'(TICK[0]), 32'd1);
        LOAD[0] = 1'b1;
        DIV[7:0] = 8'd2;
        step();
        LOAD[0] = 1'b0;
        run_pattern("wrap2", 0, 4, 32'b1010, 32'b0101);

        // Enable drop mid-period, then fresh restart.
        start(0, 8'd8);
        run_pattern("en8a", 0, 3, 32'b111, 32'b000);
        chk("en8_c3_clk", 32'(CLK_OUT[0]), 32'd1);
        ENABLE[0] = 1'b0;
        step();
        chk("stop_clk", 32'(CLK_OUT[0]), 32'd0);
        chk("stop_tick", 32'(TICK[0]), 32'd0);
        chk("stop_act", 32'(ACTIVE[0]), 32'd0);
        ENABLE[0] = 1'b1;
        step();
        run_pattern("en8b", 0, 8, 32'b11110000, 32'b00000001);

        // All four channels together, then a one-cycle reset.
        ENABLE = '0;
        LOAD   = '1;
        DIV    = {8'd255, 8'd4, 8'd3, 8'd2};
        step();
        LOAD   = '0;
        ENABLE = '1;
        step();
        pc[0] = 12'b101010101010; pt[0] = 12'b010101010101;
        pc[1] = 12'b110110110110; pt[1] = 12'b001001001001;
        pc[2] = 12'b110011001100; pt[2] = 12'b000100010001;
        pc[3] = 12'b111111111111; pt[3] = 12'b000000000000;
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 4; c++) begin
                ec[c] = pc[c][11-i];
                et[c] = pt[c][11-i];
            end
            chk("multi_clk", 32'(CLK_OUT), 32'(ec));
            chk("multi_tick", 32'(TICK), 32'(et));
            step();
        end
        RESET_N = 1'b0;
        LOAD    = '1;
        DIV     = {4{8'd9}};
        step();
        chk("mrst_clk", 32'(CLK_OUT), 32'd0);
        chk("mrst_tick", 32'(TICK), 32'd0);
        chk("mrst_act", 32'(ACTIVE), 32'd0);
        RESET_N = 1'b1;
        LOAD    = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("post_clk", 32'(CLK_OUT), (i % 2 == 0) ? 32'hF : 32'h0);
            chk("post_tick", 32'(TICK), (i % 2 == 1) ? 32'hF : 32'h0);
            chk("post_act", 32'(ACTIVE), 32'hF);
            step();
        end

`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
        begin
            int first;
            first = -1;
            start(0, 8'd3);
            step();
            step();
            start(1, 8'd7);
            step();
            step();
            step();
            SYNC = 1'b1;
            step();
            SYNC = 1'b0;
            chk("sync_clk", 32'(CLK_OUT[1:0]), 32'd3);
            for (int i = 0; i < 21; i++) begin
                if (TICK[1:0] == 2'b11 && first < 0)
                    first = i;
                step();
            end
            chk("sync_tick_coinc", 32'(first), 32'd20);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 8: width of each channel divisor (2..16).
REQ-003 SHALL have port CLK  input  1  single clock; all logic is rising-edge CLK.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ENABLE  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-006 SHALL have port LOAD  input  NUM_CH  per-channel one-cycle strobe capturing that channel's DIV slice.
REQ-007 SHALL have port DIV  input  NUM_CH*DIV_WIDTH  divisor N; channel k uses bits [k*DIV_WIDTH +: DIV_WIDTH].
REQ-008 SHALL have port CLK_OUT  output  NUM_CH  divided clock per channel, driven directly from flops.
REQ-009 SHALL have port TICK  output  NUM_CH  one-CLK-cycle strobe per divided period, driven directly from flops.
REQ-010 SHALL have port ACTIVE  output  NUM_CH  channel running (ENABLE sampled high, not halted).

Function
REQ-011 Each channel SHALL hold an active divisor Na, a pending divisor Np, a pending flag and a phase counter c (0..Na-1).
REQ-012 Captured DIV values 0 and 1 SHALL be clamped to 2.
REQ-013 While running, c SHALL advance 0,1,...,Na-1,0,... one step per CLK; first running cycle after ENABLE sampled high has c=0.
REQ-014 CLK_OUT SHALL be 1 in running cycles with c < ceil(Na/2), else 0 (odd Na: high one cycle longer than low).
REQ-015 TICK SHALL be 1 exactly in running cycles with c == Na-1; never asserted when stopped.
REQ-016 LOAD on a stopped channel SHALL write Na directly, effective on the next start.
REQ-017 LOAD on a running channel SHALL write Np and set pending; Na:=Np at the c==Na-1 -> 0 wrap, so no runt or stretched period.
REQ-018 LOAD in the same cycle as a wrap SHALL make the new value govern the period that starts next cycle.
REQ-019 A second LOAD before the wrap SHALL overwrite Np; only the last value is applied.
REQ-020 ENABLE sampled low SHALL stop the channel next cycle: c=0, CLK_OUT=0, TICK=0, ACTIVE=0; pending divisor applied immediately.
REQ-021 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-022 RESET_N low at a CLK edge SHALL set, next cycle: CLK_OUT=0, TICK=0, ACTIVE=0, c=0, pending=0, Na=2, Np=2.
REQ-023 Reset mid-period SHALL abandon the period; ENABLE and LOAD are ignored while RESET_N is low.
REQ-024 After RESET_N returns high, a channel with ENABLE high SHALL start with c=0 on the first cycle after RESET_N is sampled high.

Configuration
REQ-025 Macro CLOCK_DIVIDER_BANK_SYNC_EN defined SHALL add input port SYNC (1 bit).
REQ-026 With the macro, SYNC sampled high SHALL, next cycle, force c=0 on every running channel and apply all pending divisors, aligning all channels' rising CLK_OUT edges; SYNC with LOAD in the same cycle SHALL apply the new value immediately.
REQ-027 Without the macro, port SYNC and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-028 Reset, LOAD ch0 DIV=4, ENABLE ch0 -> CLK_OUT0 pattern 1100 repeating; TICK0 every 4th cycle, coinciding with the 4th cycle of each period.
REQ-029 DIV=5 -> CLK_OUT 11100 repeating; DIV=0 and DIV=1 -> identical to DIV=2 (10 repeating, TICK every 2 cycles).
REQ-030 Running at DIV=6, LOAD DIV=3 at c=2 -> current period completes 6 cycles, then periods of 3 (110); no period of any other length.
REQ-031 ENABLE dropped mid-period at DIV=8, c=3 -> next cycle CLK_OUT=0, ACTIVE=0; re-enable -> fresh period from c=0.
REQ-032 RESET_N low for 1 cycle while ch0..ch3 run at DIV 2,3,4,255 -> all outputs 0 next cycle, Na=2 for all; ENABLE held -> all restart at DIV 2.
REQ-033 With CLOCK_DIVIDER_BANK_SYNC_EN, channels at DIV 3 and 7 free-running, pulse SYNC -> both CLK_OUT rise on the same cycle after SYNC; TICK coincides every 21 cycles.
